cfg_loader: RTL and testbench

- Upstream feeder for the configurable logic unit's `cfg_in` byte port.
- Accepts a host configuration byte stream over a valid/ready handshake.
- Parses it into (header, payload) pairs and buffers the pairs in a small FIFO.
- Replays each pair onto `cfg_out` as two consecutive bytes, so the unit never sees a torn pair, a stray 0x7F, or a non-idle filler byte.

---
 rtl/cfg_loader.sv | 274 +++++++++++++++++++++++++++
 tb/tb_cfg_loader.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cfg_loader.sv
// Purpose: parse a host config byte stream into (header, payload) pairs, buffer them, replay each pair atomically on cfg_out.
// Latency: payload accepted at edge E (FIFO empty, emitter idle) -> header after E+1, payload after E+2, 0x00 after E+3.
// Backpressure: in_ready drops only while waiting for a payload with the FIFO full; pause holds off the start of new pairs.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_data/valid/ready   host byte stream, transfers when valid & ready
//   pause                 1 = do not start emitting a new pair
//   clear                 synchronous flush of parser and FIFO (drop_cnt kept)
//   cfg_out               registered byte stream to the unit, 0x00 when idle
//   busy                  a pair is pending anywhere in the loader
//   level                 pairs currently held in the FIFO
//   drop_cnt              saturating count of discarded non-header bytes

// Generic circular-buffer FIFO with occupancy count. Push is ignored when
// full and pop when empty; clear empties it and wins over push/pop.
module cfg_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH),
  parameter int LW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          push,
  input  logic [W-1:0]  push_dat,
  input  logic          pop,
  output logic [W-1:0]  pop_dat,
  output logic [LW-1:0] level,
  output logic          full
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == LW'(DEPTH));
  assign do_push = push && !full && !clear;
  assign do_pop  = pop && (level != '0) && !clear;

  // Head of the queue is always visible; the consumer latches it on pop.
  assign pop_dat = mem[rd_ptr];

  // Storage carries no reset: only entries below level are ever read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      // DEPTH is a power of two, so pointer overflow is the wrap.
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

module cfg_loader #(
  parameter int DEPTH = 4,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          pause,
  input  logic          clear,
  output logic [7:0]    cfg_out,
  output logic          busy,
  output logic [LW-1:0] level,
  output logic [7:0]    drop_cnt
);

  typedef struct packed {
    logic [7:0] hdr;
    logic [7:0] pay;
  } pair_t;

  typedef enum logic {
    P_HDR,
    P_PAY
  } p_state_t;

  typedef enum logic [1:0] {
    E_IDLE,
    E_CMD,
    E_DATA
  } e_state_t;

  p_state_t   p_state;
  p_state_t   p_next;
  e_state_t   e_state;
  e_state_t   e_next;

  logic       full;
  logic       xfer;
  logic       is_hdr;
  logic       hdr_load;
  logic       push;
  logic       drop;
  logic [7:0] hdr_q;
  pair_t      wr_pair;
  pair_t      rd_pair;

  logic       start_ok;
  logic       pop;
  logic [7:0] cfg_nxt;
  logic [7:0] pay_q;

  // ------------------------------------------------------------------
  // Parser
  // ------------------------------------------------------------------

  // Ready depends only on registered state, so it never loops back
  // through in_valid. No pop bypass: a full FIFO stalls the payload even
  // on the cycle the emitter pops.
  assign in_ready = (p_state == P_HDR) || !full;
  assign xfer     = in_valid && in_ready;

  // 0x7F has bit7 clear but is still a legal header.
  assign is_hdr   = in_data[7] || (in_data == 8'h7F);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_state <= P_HDR;
    end else begin
      p_state <= p_next;
    end
  end

  always_comb begin
    p_next = p_state;
    if (clear) begin
      p_next = P_HDR;
    end else if (xfer) begin
      unique case (p_state)
        P_HDR: p_next = is_hdr ? P_PAY : P_HDR;
        P_PAY: p_next = P_HDR;
      endcase
    end
  end

  // Clear suppresses every side effect of a byte transferred that cycle.
  always_comb begin
    hdr_load = 1'b0;
    push     = 1'b0;
    drop     = 1'b0;
    if (xfer && !clear) begin
      unique case (p_state)
        P_HDR: begin
          hdr_load = is_hdr;
          drop     = !is_hdr;
        end
        P_PAY: push = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hdr_q    <= 8'h00;
      drop_cnt <= 8'h00;
    end else begin
      if (hdr_load) begin
        hdr_q <= in_data;
      end
      if (drop && (drop_cnt != 8'hFF)) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

  assign wr_pair.hdr = hdr_q;
  assign wr_pair.pay = in_data;

  cfg_fifo #(
    .W     ($bits(pair_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .push     (push),
    .push_dat (wr_pair),
    .pop      (pop),
    .pop_dat  (rd_pair),
    .level    (level),
    .full     (full)
  );

  // ------------------------------------------------------------------
  // Emitter
  // ------------------------------------------------------------------

  // A new pair may start only from IDLE or straight after a payload;
  // clear also blocks the start so a flushed FIFO is never read.
  assign start_ok = (level != '0) && !pause && !clear;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_state <= E_IDLE;
    end else begin
      e_state <= e_next;
    end
  end

  always_comb begin
    e_next = e_state;
    case (e_state)
      E_IDLE:  e_next = start_ok ? E_CMD : E_IDLE;
      E_CMD:   e_next = E_DATA;
      E_DATA:  e_next = start_ok ? E_CMD : E_IDLE;
      default: e_next = E_IDLE;
    endcase
  end

  // The header leaves the FIFO on the pop edge; its payload is parked in
  // pay_q so the pair finishes even if clear empties the FIFO meanwhile.
  always_comb begin
    pop     = 1'b0;
    cfg_nxt = 8'h00;
    case (e_state)
      E_IDLE, E_DATA: begin
        if (start_ok) begin
          pop     = 1'b1;
          cfg_nxt = rd_pair.hdr;
        end
      end
      E_CMD:   cfg_nxt = pay_q;
      default: cfg_nxt = 8'h00;
    endcase
  end

  // cfg_out sits on the async reset so a mid-pair reset idles the unit
  // without waiting for a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_out <= 8'h00;
      pay_q   <= 8'h00;
    end else begin
      cfg_out <= cfg_nxt;
      if (pop) begin
        pay_q <= rd_pair.pay;
      end
    end
  end

  assign busy = (p_state == P_PAY) || (level != '0) || (e_state != E_IDLE);

endmodule

// File: tb/tb_cfg_loader.sv
module tb_cfg_loader;

  logic       clk;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       pause;
  logic       clear;
  logic [7:0] cfg_out;
  logic       busy;
  logic [2:0] level;
  logic [7:0] drop_cnt;

  int n_total = 0;
  int n_pass  = 0;

  // Scoreboard: header then payload of each pair expected on cfg_out.
  logic [7:0] exp_q[$];
  bit         expect_pay = 1'b0;
  logic [7:0] exp_pay;
  logic [7:0] exp_hdr;

  cfg_loader #(.DEPTH(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .pause    (pause),
    .clear    (clear),
    .cfg_out  (cfg_out),
    .busy     (busy),
    .level    (level),
    .drop_cnt (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard consumer: any non-idle byte outside a pair must be the next
  // expected header; the byte after a header is always its payload.
  always @(negedge clk) begin
    if (!rst_n) begin
      expect_pay = 1'b0;
    end else if (expect_pay) begin
      n_total++;
      if (cfg_out !== exp_pay) $display("FAIL sb_payload: got %02h want %02h", cfg_out, exp_pay);
      else n_pass++;
      expect_pay = 1'b0;
    end else if (cfg_out !== 8'h00) begin
      n_total++;
      if (exp_q.size() < 2) begin
        $display("FAIL sb_stray: got %02h want 00 (nothing queued)", cfg_out);
      end else begin
        exp_hdr = exp_q.pop_front();
        exp_pay = exp_q.pop_front();
        expect_pay = 1'b1;
        if (cfg_out !== exp_hdr) $display("FAIL sb_header: got %02h want %02h", cfg_out, exp_hdr);
        else n_pass++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Offer one byte from a negedge and hold it until it transfers.
  task automatic send(input logic [7:0] b);
    int waited;
    waited = 0;
    @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      n_total++;
      $display("FAIL send_timeout: in_ready got 0 want 1 for byte %02h", b);
    end else begin
      @(posedge clk);
    end
    #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_total++;
    if (cfg_out !== 8'h00) $display("FAIL reset_cfg_out: got %02h want 00", cfg_out); else n_pass++;
    n_total++;
    if (level !== 3'd0) $display("FAIL reset_level: got %0d want 0", level); else n_pass++;
    n_total++;
    if (busy !== 1'b0 || drop_cnt !== 8'h00) $display("FAIL reset_busy_drop: got %b/%02h want 0/00", busy, drop_cnt); else n_pass++;
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else n_pass++;
  endtask

  task automatic test_single_pair;
    send(8'h85);
    send(8'h3C);
    exp_q.push_back(8'h85);
    exp_q.push_back(8'h3C);
    @(negedge clk);
    n_total++;
    if (cfg_out !== 8'h00 || level !== 3'd1 || busy !== 1'b1) $display("FAIL single_e0: got %02h/%0d/%b want 00/1/1", cfg_out, level, busy); else n_pass++;
    @(negedge clk);
    n_total++;
    if (cfg_out !== 8'h85) $display("FAIL single_hdr: got %02h want 85", cfg_out); else n_pass++;
    @(negedge clk);
    n_total++;
    if (cfg_out !== 8'h3C) $display("FAIL single_pay: got %02h want 3C", cfg_out); else n_pass++;
    @(negedge clk);
    n_total++;
    if (cfg_out !== 8'h00 || level !== 3'd0 || busy !== 1'b0) $display("FAIL single_end: got %02h/%0d/%b want 00/0/0", cfg_out, level, busy); else n_pass++;
  endtask

  task automatic test_junk;
    send(8'h12);
    send(8'h00);
    send(8'h7E);
    @(negedge clk);
    n_total++;
    if (drop_cnt !== 8'd3 || busy !== 1'b0) $display("FAIL junk_drop: got %0d/%b want 3/0", drop_cnt, busy); else n_pass++;
    send(8'h7F);
    send(8'hF0);
    exp_q.push_back(8'h7F);
    exp_q.push_back(8'hF0);
    tick(6);
    n_total++;
    if (exp_q.size() != 0 || drop_cnt !== 8'd3) $display("FAIL junk_drain: got q=%0d drop=%0d want q=0 drop=3", exp_q.size(), drop_cnt); else n_pass++;
  endtask

  task automatic test_backpressure;
    logic [7:0] seq [8];
    seq = '{8'h80, 8'h01, 8'h81, 8'h02, 8'h82, 8'h03, 8'h83, 8'h04};
    pause = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(8'(8'h80 + i));
      send(8'(8'h01 + i));
      exp_q.push_back(8'(8'h80 + i));
      exp_q.push_back(8'(8'h01 + i));
    end
    send(8'h84);
    @(negedge clk);
    n_total++;
    if (level !== 3'd4) $display("FAIL bp_level_full: got %0d want 4", level); else n_pass++;
    n_total++;
    if (in_ready !== 1'b0) $display("FAIL bp_in_ready_full: got %b want 0", in_ready); else n_pass++;
    pause    = 1'b0;
    in_data  = 8'h55;
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_total++;
      if (cfg_out !== seq[i]) $display("FAIL bp_seq[%0d]: got %02h want %02h", i, cfg_out, seq[i]); else n_pass++;
      if (i == 0) begin
        n_total++;
        if (in_ready !== 1'b1 || level !== 3'd3) $display("FAIL bp_after_pop: got ready=%b level=%0d want 1/3", in_ready, level); else n_pass++;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        exp_q.push_back(8'h84);
        exp_q.push_back(8'h55);
      end
    end
    tick(4);
    n_total++;
    if (exp_q.size() != 0 || level !== 3'd0) $display("FAIL bp_drain: got q=%0d level=%0d want 0/0", exp_q.size(), level); else n_pass++;
  endtask

  task automatic test_pause_mid_pair;
    bit found;
    found = 1'b0;
    pause = 1'b1;
    send(8'h85);
    send(8'h11);
    send(8'h86);
    send(8'h22);
    exp_q.push_back(8'h85);
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h86);
    exp_q.push_back(8'h22);
    pause = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      if (cfg_out === 8'h85) found = 1'b1;
    end
    pause = 1'b1;
    n_total++;
    if (!found) $display("FAIL pause_hdr_seen: got no 85 want 85 within 10 cycles"); else n_pass++;
    @(negedge clk);
    n_total++;
    if (cfg_out !== 8'h11) $display("FAIL pause_payload: got %02h want 11", cfg_out); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_total++;
      if (cfg_out !== 8'h00 || level !== 3'd1) $display("FAIL pause_hold[%0d]: got %02h/%0d want 00/1", k, cfg_out, level); else n_pass++;
    end
    pause = 1'b0;
    tick(5);
    n_total++;
    if (exp_q.size() != 0 || busy !== 1'b0) $display("FAIL pause_drain: got q=%0d busy=%b want 0/0", exp_q.size(), busy); else n_pass++;
  endtask

  task automatic test_clear;
    bit found;
    found = 1'b0;
    pause = 1'b1;
    send(8'h88);
    send(8'h01);
    exp_q.push_back(8'h88);
    exp_q.push_back(8'h01);
    send(8'h89);
    send(8'h02);
    send(8'h8A);
    send(8'h03);
    send(8'h8B);
    pause = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      if (cfg_out === 8'h88) found = 1'b1;
    end
    n_total++;
    if (!found) $display("FAIL clear_hdr_seen: got no 88 want 88 within 10 cycles"); else n_pass++;
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    @(negedge clk);
    n_total++;
    if (cfg_out !== 8'h01 || level !== 3'd0 || busy !== 1'b1) $display("FAIL clear_payload: got %02h/%0d/%b want 01/0/1", cfg_out, level, busy); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_total++;
      if (cfg_out !== 8'h00) $display("FAIL clear_idle[%0d]: got %02h want 00", k, cfg_out); else n_pass++;
    end
    n_total++;
    if (busy !== 1'b0 || drop_cnt !== 8'd3) $display("FAIL clear_state: got busy=%b drop=%0d want 0/3", busy, drop_cnt); else n_pass++;
    send(8'h90);
    send(8'h5A);
    exp_q.push_back(8'h90);
    exp_q.push_back(8'h5A);
    tick(6);
    n_total++;
    if (exp_q.size() != 0) $display("FAIL clear_new_pair: got q=%0d want 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_async_reset;
    bit found;
    found = 1'b0;
    send(8'hA0);
    send(8'h5B);
    exp_q.push_back(8'hA0);
    exp_q.push_back(8'h5B);
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      if (cfg_out === 8'hA0) found = 1'b1;
    end
    n_total++;
    if (!found) $display("FAIL areset_hdr_seen: got no A0 want A0 within 10 cycles"); else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_total++;
    if (cfg_out !== 8'h00) $display("FAIL areset_cfg_out: got %02h want 00", cfg_out); else n_pass++;
    n_total++;
    if (level !== 3'd0 || busy !== 1'b0 || drop_cnt !== 8'h00) $display("FAIL areset_counters: got %0d/%b/%02h want 0/0/00", level, busy, drop_cnt); else n_pass++;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 300; i++) begin
      send(8'(i % 127));
      if (i == 253) begin
        n_total++;
        if (drop_cnt !== 8'hFE) $display("FAIL drop_254: got %02h want FE", drop_cnt); else n_pass++;
      end
    end
    n_total++;
    if (drop_cnt !== 8'hFF) $display("FAIL drop_sat: got %02h want FF", drop_cnt); else n_pass++;
    tick(2);
    n_total++;
    if (cfg_out !== 8'h00 || busy !== 1'b0) $display("FAIL junk_quiet: got %02h/%b want 00/0", cfg_out, busy); else n_pass++;
  endtask

  initial begin
    rst_n    = 1'b0;
    in_data  = 8'h00;
    in_valid = 1'b0;
    pause    = 1'b0;
    clear    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    test_reset();
    test_single_pair();
    test_junk();
    test_backpressure();
    test_pause_mid_pair();
    test_clear();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
